join_16b_assembler: RTL and testbench



---
 rtl/join_16b_assembler.sv | 84 ++++++++
 tb/tb_join_16b_assembler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/join_16b_assembler.sv
// rtl/join_16b_assembler.sv - byte-to-word assembler with one-word output buffer
// Pairs consecutive bytes into 16-bit words; byte order selected by HIGH_FIRST.
module join_16b_assembler #(
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        partial,
  output logic [7:0]  word_count
);

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  phase_t      phase;
  phase_t      phase_next;
  logic [7:0]  hold;
  logic        byte_fire;
  logic        load_word;
  logic        drain;
  logic [15:0] word_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_FIRST;
    end else begin
      phase <= phase_next;
    end
  end

  // A second byte may only land when the output slot is empty or draining now.
  always_comb begin
    byte_ready = 1'b0;
    byte_fire  = 1'b0;
    load_word  = 1'b0;
    phase_next = phase;
    byte_ready = !rst && !clr &&
                 !((phase == PH_SECOND) && word_valid && !word_ready);
    byte_fire  = byte_valid && byte_ready;
    load_word  = byte_fire && (phase == PH_SECOND);
    if (clr) begin
      phase_next = PH_FIRST;
    end else if (byte_fire) begin
      phase_next = (phase == PH_FIRST) ? PH_SECOND : PH_FIRST;
    end
  end

  assign drain     = word_valid && word_ready;
  assign word_next = HIGH_FIRST ? {hold, byte_in} : {byte_in, hold};
  assign partial   = (phase == PH_SECOND);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= 8'h00;
      word_out   <= 16'h0000;
      word_valid <= 1'b0;
      word_count <= 8'h00;
    end else begin
      if (byte_fire && (phase == PH_FIRST)) begin
        hold <= byte_in;
      end
      // A fresh word replaces a draining one without a bubble.
      if (load_word) begin
        word_out   <= word_next;
        word_valid <= 1'b1;
      end else if (drain) begin
        word_valid <= 1'b0;
      end
      if (drain) begin
        word_count <= word_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_join_16b_assembler.sv
// tb/tb_join_16b_assembler.sv - directed self-checking bench for join_16b_assembler
// Low-first and high-first instances share inputs and handshake behaviour.
module tb_join_16b_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        word_ready;
  logic        byte_ready, byte_ready_hi;
  logic [15:0] word_out, word_out_hi;
  logic        word_valid, word_valid_hi;
  logic        partial, partial_hi;
  logic [7:0]  word_count, word_count_hi;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  join_16b_assembler #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .clr(clr), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .partial(partial), .word_count(word_count)
  );

  join_16b_assembler #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .clr(clr), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready_hi), .word_out(word_out_hi), .word_valid(word_valid_hi),
    .word_ready(word_ready), .partial(partial_hi), .word_count(word_count_hi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; word_ready = 1'b1;
    step();
    step();
    check("rst_word_valid", word_valid, 0);
    check("rst_word_out", word_out, 16'h0000);
    check("rst_count", word_count, 0);
    check("rst_partial", partial, 0);
    check("rst_byte_ready", byte_ready, 0);

    // low-first / high-first pairing 34,12
    rst = 1'b0; byte_valid = 1'b1; byte_in = 8'h34;
    #1;
    check("t1_byte_ready", byte_ready, 1);
    check("t1_partial0", partial, 0);
    step();
    check("t1_partial1", partial, 1);
    check("t1_valid_early", word_valid, 0);
    byte_in = 8'h12;
    step();
    check("t1_valid", word_valid, 1);
    check("t1_word_lo", word_out, 16'h1234);
    check("t1_word_hi", word_out_hi, 16'h3412);
    check("t1_partial2", partial, 0);
    byte_valid = 1'b0;
    step();
    check("t1_valid_one_cycle", word_valid, 0);
    check("t1_count", word_count, 1);

    // AB, CD
    byte_valid = 1'b1; byte_in = 8'hAB;
    step();
    byte_in = 8'hCD;
    step();
    check("t2_word_hi", word_out_hi, 16'hABCD);
    check("t2_word_lo", word_out, 16'hCDAB);
    byte_valid = 1'b0;
    step();
    check("t2_count", word_count, 2);
    check("t2_count_hi", word_count_hi, 2);

    // back-pressure 01..04
    word_ready = 1'b0; byte_valid = 1'b1; byte_in = 8'h01;
    step();
    byte_in = 8'h02;
    step();
    check("t3_word", word_out, 16'h0201);
    check("t3_valid", word_valid, 1);
    byte_in = 8'h03;
    #1;
    check("t3_ready_first", byte_ready, 1);
    step();
    check("t3_partial", partial, 1);
    check("t3_word_held", word_out, 16'h0201);
    byte_in = 8'h04;
    #1;
    check("t3_ready_stall", byte_ready, 0);
    step();
    check("t3_word_still", word_out, 16'h0201);
    check("t3_partial_still", partial, 1);
    check("t3_count_still", word_count, 2);
    word_ready = 1'b1;
    #1;
    check("t3_ready_drain", byte_ready, 1);
    step();
    check("t3_word2", word_out, 16'h0403);
    check("t3_valid2", word_valid, 1);
    check("t3_count_drain", word_count, 3);
    check("t3_partial_after", partial, 0);
    byte_valid = 1'b0;
    step();
    check("t3_count_final", word_count, 4);
    check("t3_valid_final", word_valid, 0);

    // clr mid-pair
    byte_valid = 1'b1; byte_in = 8'h55;
    step();
    check("t4_partial", partial, 1);
    clr = 1'b1; byte_in = 8'h66;
    #1;
    check("t4_ready_clr", byte_ready, 0);
    step();
    check("t4_partial_clr", partial, 0);
    check("t4_no_word", word_valid, 0);
    clr = 1'b0; byte_in = 8'h11;
    step();
    byte_in = 8'h22;
    step();
    check("t4_word", word_out, 16'h2211);
    check("t4_word_hi", word_out_hi, 16'h1122);
    byte_valid = 1'b0;
    step();
    check("t4_count", word_count, 5);

    // counter wrap: 250 more words at full rate
    byte_valid = 1'b1;
    for (int i = 0; i < 250; i++) begin
      byte_in = 8'(2 * i);
      step();
      byte_in = 8'(2 * i + 1);
      step();
    end
    check("t5_last_word", word_out, 16'hF3F2);
    byte_valid = 1'b0;
    step();
    check("t5_count_255", word_count, 255);
    byte_valid = 1'b1; byte_in = 8'hEE;
    step();
    byte_in = 8'hFF;
    step();
    byte_valid = 1'b0;
    step();
    check("t5_count_wrap", word_count, 0);

    // reset with partial and pending word
    word_ready = 1'b0; byte_valid = 1'b1; byte_in = 8'hBC;
    step();
    byte_in = 8'h9A;
    step();
    byte_in = 8'hDE;
    step();
    check("t6_pre_partial", partial, 1);
    check("t6_pre_valid", word_valid, 1);
    check("t6_pre_word", word_out, 16'h9ABC);
    rst = 1'b1; byte_valid = 1'b0;
    #1;
    check("t6_ready_rst", byte_ready, 0);
    step();
    check("t6_valid", word_valid, 0);
    check("t6_word", word_out, 16'h0000);
    check("t6_partial", partial, 0);
    check("t6_count", word_count, 0);
    rst = 1'b0; word_ready = 1'b1; byte_valid = 1'b1; byte_in = 8'h78;
    step();
    byte_in = 8'h56;
    step();
    check("t6_word_after", word_out, 16'h5678);
    byte_valid = 1'b0;
    step();
    check("t6_count_after", word_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
